// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
//   WB_XLEN / WB_NREGS / WB_ADDR_W : default result width, register count, address width
//   ZERO_REG                       : hard-wired zero register; results aimed at it are dropped
//   wb_entry_t                     : one buffered result {rd, data} at the default widths
package wb_pkg;

    localparam int unsigned WB_XLEN   = 32;
    localparam int unsigned WB_NREGS  = 32;
    localparam int unsigned WB_ADDR_W = $clog2(WB_NREGS);
    localparam int unsigned ZERO_REG  = 0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   req        : per-requester request
//   advance    : allow the pointer to move past this cycle's winner
//   grant      : one-hot grant, first requester at or after the pointer
//   any        : some requester was granted
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         any
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int unsigned      idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: buffers one completed result per functional unit, round-robin
// arbitrates them onto the single register-file write port and pulses the scoreboard
// clear for the same register in the same cycle as the write.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop every buffered result; no grant this cycle
//   src_valid/ready   : per-source handshake; src_rd / src_data carry the result
//   rf_we/waddr/wdata : registered register-file write
//   sb_clear/sb_addr  : registered scoreboard clear, identical timing and address to the write
//   pending           : number of occupied holding slots after the last edge
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned XLEN    = WB_XLEN,
    parameter int unsigned NREGS   = WB_NREGS,
    localparam int unsigned ADDR_W = $clog2(NREGS),
    localparam int unsigned CNT_W  = $clog2(NUM_SRC + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]   src_rd,
    input  logic [NUM_SRC-1:0][XLEN-1:0]     src_data,
    output logic                             rf_we,
    output logic [ADDR_W-1:0]                rf_waddr,
    output logic [XLEN-1:0]                  rf_wdata,
    output logic                             sb_clear,
    output logic [ADDR_W-1:0]                sb_addr,
    output logic [CNT_W-1:0]                 pending
);

    logic [NUM_SRC-1:0]             hold_valid_q, hold_valid_d;
    logic [NUM_SRC-1:0][ADDR_W-1:0] hold_rd_q, hold_rd_d;
    logic [NUM_SRC-1:0][XLEN-1:0]   hold_data_q, hold_data_d;

    logic                           rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]              rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]                rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]               pending_q, pending_d;

    logic [NUM_SRC-1:0]             arb_req;
    logic [NUM_SRC-1:0]             grant;
    logic                           grant_any;
    logic [NUM_SRC-1:0]             accept;

    // Flush suppresses arbitration so buffered results are dropped rather than written.
    assign arb_req = flush ? '0 : hold_valid_q;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (!flush),
        .grant   (grant),
        .any     (grant_any)
    );

    // A slot being granted this cycle can take a new result at the same edge.
    assign src_ready = (reset || flush) ? '0 : (~hold_valid_q | grant);
    assign accept    = src_valid & src_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (accept[i] && (src_rd[i] != ADDR_W'(ZERO_REG))) begin
                hold_valid_d[i] = 1'b1;
                hold_rd_d[i]    = src_rd[i];
                hold_data_d[i]  = src_data[i];
            end else if (grant[i]) begin
                // Also covers an x0 result arriving on a draining slot: it is simply lost.
                hold_valid_d[i] = 1'b0;
            end
        end
        if (flush) begin
            hold_valid_d = '0;
        end
    end

    always_comb begin
        rf_we_d    = grant_any;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                rf_waddr_d = hold_rd_q[i];
                rf_wdata_d = hold_data_q[i];
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pending_d = pending_d + CNT_W'(hold_valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= '0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pending_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pending_q    <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    // The clear shares the write flops so the two can never drift apart.
    assign sb_clear = rf_we_q;
    assign sb_addr  = rf_waddr_q;
    assign pending  = pending_q;

endmodule
